// File: rtl/hazard5_ahbl_arbiter_pkg.sv
// hazard5 AHB-Lite arbiter: shared bus encodings
// and helpers.
package hazard5_ahbl_arbiter_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE = 2'b00,
      HTRANS_NSEQ = 2'b10
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000
   } hburst_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   function automatic int wait_width(int max_wait);
      return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
   endfunction

endpackage

// File: rtl/hazard5_ahbl_arbiter_if.sv
// hazard5 AHB-Lite master-side bus bundle between
// the arbiter and the downstream slave/fabric.
interface hazard5_ahbl_arbiter_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic [W_ADDR-1:0] haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic              hmastlock;
   logic              hready;
   logic              hresp;
   logic [W_DATA-1:0] hwdata;
   logic [W_DATA-1:0] hrdata;

   modport master (
      output haddr, hwrite, htrans, hsize,
      output hburst, hprot, hmastlock, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  haddr, hwrite, htrans, hsize,
      input  hburst, hprot, hmastlock, hwdata,
      output hready, hresp, hrdata
   );
endinterface

// File: rtl/hazard5_onehot_prio_enc.sv
// Lowest-set one-hot picker, searching upward from
// the bit after the one-hot base and wrapping.
module hazard5_onehot_prio_enc #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] base,
   output logic [N-1:0] gnt
);
   localparam logic [N-1:0]   ONE  = N'(1);
   localparam logic [2*N-1:0] ONE2 = (2*N)'(1);

   logic [N-1:0]   above;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] lo;

   // Base at MSB leaves no bits above it: plain lowest-index.
   assign above = ~(base | (base - ONE));
   assign dbl   = {req, req & above};
   assign lo    = dbl & (~dbl + ONE2);
   assign gnt   = lo[N-1:0] | lo[2*N-1:N];
endmodule

// File: rtl/hazard5_ahbl_arbiter.sv
// hazard5 N-source AHB-Lite master arbiter with
// panic override, RR/fixed priority and anti-starvation.
module hazard5_ahbl_arbiter
   import hazard5_ahbl_arbiter_pkg::*;
#(
   parameter int N_PORTS  = 2,
   parameter int W_ADDR   = 32,
   parameter int W_DATA   = 32,
   parameter bit RR_MODE  = 0,
   parameter int MAX_WAIT = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_PORTS-1:0]        src_aph_req,
   input  logic [N_PORTS-1:0]        src_aph_panic,
   input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
   input  logic [N_PORTS*3-1:0]      src_hsize,
   input  logic [N_PORTS-1:0]        src_hwrite,
   input  logic [N_PORTS*4-1:0]      src_hprot,
   input  logic [N_PORTS*W_DATA-1:0] src_wdata,
   output logic [N_PORTS-1:0]        src_aph_ready,
   output logic [N_PORTS-1:0]        src_dph_ready,
   output logic [N_PORTS-1:0]        src_dph_err,
   output logic [W_DATA-1:0]         src_rdata,
   hazard5_ahbl_arbiter_if.master    ahblm
);
   localparam int W_WAIT = wait_width(MAX_WAIT);
   localparam logic [W_WAIT-1:0] WAIT_MAX = W_WAIT'(MAX_WAIT);
   localparam logic [W_WAIT-1:0] WAIT_ONE = W_WAIT'(1);
   localparam logic [N_PORTS-1:0] MSB =
      {1'b1, {(N_PORTS-1){1'b0}}};

   logic               hold_aph;
   logic [N_PORTS-1:0] gnt_prev, dph_owner, last_gnt;
   logic [N_PORTS-1:0] gnt, accepted, dph_live;
   logic [N_PORTS-1:0] panic, starved;
   logic [N_PORTS-1:0] panic_gnt, boost_gnt, norm_gnt;
   logic [W_WAIT-1:0]  wait_cnt [N_PORTS];
   logic [W_ADDR-1:0]  haddr;
   logic [2:0]         hsize;
   logic [3:0]         hprot;
   logic [W_DATA-1:0]  hwdata;

   assign panic = src_aph_panic & src_aph_req;

   always_comb begin
      starved = '0;
      for (int k = 0; k < N_PORTS; k++)
         starved[k] = (MAX_WAIT > 0) && src_aph_req[k]
                      && (wait_cnt[k] == WAIT_MAX);
   end

   hazard5_onehot_prio_enc #(.N(N_PORTS)) u_panic (
      .req(panic), .base(MSB), .gnt(panic_gnt)
   );
   hazard5_onehot_prio_enc #(.N(N_PORTS)) u_boost (
      .req(starved), .base(MSB), .gnt(boost_gnt)
   );
   hazard5_onehot_prio_enc #(.N(N_PORTS)) u_norm (
      .req(src_aph_req),
      .base(RR_MODE ? last_gnt : MSB),
      .gnt(norm_gnt)
   );

   // A stalled address phase must be re-presented unchanged.
   always_comb begin
      gnt = '0;
      if (!rst_n)          gnt = '0;
      else if (hold_aph)   gnt = gnt_prev;
      else if (|panic)     gnt = panic_gnt;
      else if (|starved)   gnt = boost_gnt;
      else                 gnt = norm_gnt;
   end

   assign accepted = gnt & {N_PORTS{ahblm.hready}};
   assign dph_live = rst_n ? dph_owner : '0;

   always_comb begin
      haddr  = '0;
      hsize  = '0;
      hprot  = '0;
      hwdata = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (gnt[k]) begin
            haddr |= src_haddr[k*W_ADDR +: W_ADDR];
            hsize |= src_hsize[k*3 +: 3];
            hprot |= src_hprot[k*4 +: 4];
         end
         if (dph_live[k])
            hwdata |= src_wdata[k*W_DATA +: W_DATA];
      end
   end

   assign ahblm.haddr     = haddr;
   assign ahblm.hsize     = hsize;
   assign ahblm.hprot     = hprot;
   assign ahblm.hwrite    = |(gnt & src_hwrite);
   assign ahblm.htrans    = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
   assign ahblm.hburst    = HBURST_SINGLE;
   assign ahblm.hmastlock = 1'b0;
   assign ahblm.hwdata    = hwdata;

   assign src_aph_ready = accepted;
   assign src_dph_ready = dph_live & {N_PORTS{ahblm.hready}};
   assign src_dph_err   = src_dph_ready & {N_PORTS{ahblm.hresp}};
   assign src_rdata     = ahblm.hrdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_aph  <= 1'b0;
         gnt_prev  <= '0;
         dph_owner <= '0;
         last_gnt  <= MSB;
         for (int k = 0; k < N_PORTS; k++)
            wait_cnt[k] <= '0;
      end else begin
         hold_aph <= (|gnt) && !ahblm.hready;
         gnt_prev <= gnt;
         if (ahblm.hready)
            dph_owner <= gnt;
         if (|accepted)
            last_gnt <= gnt;
         for (int k = 0; k < N_PORTS; k++) begin
            if (!src_aph_req[k] || accepted[k])
               wait_cnt[k] <= '0;
            else if (wait_cnt[k] != WAIT_MAX)
               wait_cnt[k] <= wait_cnt[k] + WAIT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_hazard5_ahbl_arbiter.sv
// Randomised scoreboard bench for hazard5_ahbl_arbiter
// (3 ports, round-robin, starvation limit 4).
module tb_hazard5_ahbl_arbiter;
   localparam int N  = 3;
   localparam int MW = 4;
   localparam int NCYC = 2200;

   typedef struct {
      int          port;
      logic [31:0] wdata;
   } item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req = '0;
   logic [N-1:0]   panic = '0;
   logic [N-1:0]   hwr = '0;
   logic [31:0]    addr [N];
   logic [31:0]    wd [N];
   logic [2:0]     hs [N];
   logic [3:0]     hp [N];
   logic [N*32-1:0] f_addr, f_wd;
   logic [N*3-1:0]  f_hs;
   logic [N*4-1:0]  f_hp;
   logic [N-1:0]   aph_ready, dph_ready, dph_err;
   logic [31:0]    rdata;

   hazard5_ahbl_arbiter_if #(.W_ADDR(32), .W_DATA(32)) bus ();

   always_comb begin
      f_addr = '0;
      f_wd   = '0;
      f_hs   = '0;
      f_hp   = '0;
      for (int k = 0; k < N; k++) begin
         f_addr[k*32 +: 32] = addr[k];
         f_wd[k*32 +: 32]   = wd[k];
         f_hs[k*3 +: 3]     = hs[k];
         f_hp[k*4 +: 4]     = hp[k];
      end
   end

   hazard5_ahbl_arbiter #(
      .N_PORTS(N), .W_ADDR(32), .W_DATA(32),
      .RR_MODE(1'b1), .MAX_WAIT(MW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .src_aph_req(req),
      .src_aph_panic(panic),
      .src_haddr(f_addr),
      .src_hsize(f_hs),
      .src_hwrite(hwr),
      .src_hprot(f_hp),
      .src_wdata(f_wd),
      .src_aph_ready(aph_ready),
      .src_dph_ready(dph_ready),
      .src_dph_err(dph_err),
      .src_rdata(rdata),
      .ahblm(bus)
   );

   int total = 0;
   int bad = 0;

   // Reference model state
   bit    m_hold;
   int    m_prev;
   int    m_last;
   int    m_wait [N];
   item_t q [$];
   logic [N-1:0] acc;
   int    err_state = 0;
   bit    drain = 0;

   task automatic chk(string nm, logic [63:0] act,
                      logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold = 1'b0;
      m_prev = -1;
      m_last = N - 1;
      for (int k = 0; k < N; k++) m_wait[k] = 0;
      q.delete();
   endtask

   // Which port the spec's priority rules pick this cycle.
   function automatic int pick();
      if (!rst_n) return -1;
      if (m_hold) return m_prev;
      for (int k = 0; k < N; k++)
         if (req[k] && panic[k]) return k;
      for (int k = 0; k < N; k++)
         if (req[k] && m_wait[k] == MW) return k;
      for (int i = 1; i <= N; i++) begin
         int k = (m_last + i) % N;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      w = pick();
      acc = '0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (bus.hready) begin
         chk("dph_done", 64'(q.size()), 64'(0));
         q.delete();
         if (w >= 0) begin
            acc[w] = 1'b1;
            wd[w] = $urandom;
            q.push_back('{w, wd[w]});
            m_last = w;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (!req[k] || acc[k]) m_wait[k] = 0;
         else if (m_wait[k] < MW) m_wait[k]++;
      end
      m_hold = (w >= 0) && !bus.hready;
      m_prev = w;
   endtask

   task automatic drive_sources();
      for (int k = 0; k < N; k++) begin
         if (!req[k] || acc[k]) begin
            if (!drain && $urandom_range(0, 1) == 1) begin
               req[k]  = 1'b1;
               addr[k] = $urandom & 32'hffff_fffc;
               hs[k]   = 3'($urandom_range(0, 2));
               hwr[k]  = 1'($urandom);
               hp[k]   = 4'($urandom);
            end else begin
               req[k] = 1'b0;
            end
         end
         panic[k] = req[k] && ($urandom_range(0, 9) == 0);
      end
   endtask

   task automatic drive_slave();
      int r;
      bus.hrdata = $urandom;
      r = $urandom_range(0, 7);
      if (err_state != 0) begin
         bus.hready = 1'b1;
         bus.hresp  = 1'b1;
         err_state  = 0;
      end else if (!drain && r == 0 && q.size() > 0) begin
         bus.hready = 1'b0;
         bus.hresp  = 1'b1;
         err_state  = 1;
      end else if (!drain && r < 3) begin
         bus.hready = 1'b0;
         bus.hresp  = 1'b0;
      end else begin
         bus.hready = 1'b1;
         bus.hresp  = 1'b0;
      end
   endtask

   // Monitor: address-phase checks plus data-phase pops.
   initial begin
      int w;
      logic [N-1:0] e;
      item_t it;
      forever begin
         @(negedge clk);
         w = pick();
         e = '0;
         if (rst_n && bus.hready && w >= 0) e[w] = 1'b1;
         chk("aph_ready", 64'(aph_ready), 64'(e));
         chk("htrans", 64'(bus.htrans),
             (w >= 0) ? 64'(2) : 64'(0));
         chk("fixed_ctrl", 64'({bus.hburst, bus.hmastlock}),
             64'(0));
         if (w >= 0)
            chk("aph_ctrl",
                64'({bus.haddr, bus.hsize, bus.hwrite, bus.hprot}),
                64'({addr[w], hs[w], hwr[w], hp[w]}));
         if (!rst_n) begin
            chk("rst_outs",
                64'({aph_ready, dph_ready, dph_err}), 64'(0));
         end else if (dph_ready != '0) begin
            if (q.size() == 0) begin
               chk("dph_spurious", 64'(dph_ready), 64'(0));
            end else begin
               it = q.pop_front();
               e = '0;
               e[it.port] = 1'b1;
               chk("dph_port", 64'(dph_ready), 64'(e));
               chk("hwdata", 64'(bus.hwdata), 64'(it.wdata));
               chk("dph_err", 64'(dph_err),
                   bus.hresp ? 64'(e) : 64'(0));
               chk("rdata", 64'(rdata), 64'(bus.hrdata));
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         addr[k] = '0;
         wd[k]   = '0;
         hs[k]   = '0;
         hp[k]   = '0;
      end
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = '0;
      acc = '0;
      model_reset();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_step();
         #1;
         rst_n = !(cyc < 3 || (cyc >= 1000 && cyc < 1002));
         drain = (cyc >= NCYC - 60);
         drive_sources();
         drive_slave();
      end
      @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
